column_result_fifo_array: RTL and testbench

Bank of `array_size` independent show-ahead FIFOs, one per systolic-array column. Each FIFO buffers the finished output-feature-map values that its column produces. The bank sits directly upstream of `buffer_fill_array`: each column's `is_empty` feeds that block's `is_empty[i]`, and that block's `write_enable[i]` returns here as `rd_en[i]`. `rd_data[i]` is the value written to the output buffer at `c_address[i]`.

---
 rtl/column_result_fifo_array_pkg.sv | 6 +
 rtl/column_fifo.sv | 49 ++++
 rtl/column_result_fifo_array.sv | 36 +++
 tb/tb_column_result_fifo_array.sv | 128 ++++++++++++
 4 files changed

// File: rtl/column_result_fifo_array_pkg.sv
// column_result_fifo_array_pkg: default geometry shared by the result FIFO bank
package column_result_fifo_array_pkg;
  localparam int DATA_SIZE  = 16;
  localparam int ARRAY_SIZE = 9;
  localparam int FIFO_DEPTH = 16;
endpackage

// File: rtl/column_fifo.sv
// column_fifo: one show-ahead FIFO; w_clk/reset(active-low)/clear in, wr_en/wr_data push, rd_en pop, rd_data head, is_empty/is_full/overflow/underflow status
module column_fifo
  import column_result_fifo_array_pkg::*;
#(
  parameter int data_size  = DATA_SIZE,
  parameter int fifo_depth = FIFO_DEPTH
) (
  input  logic                 w_clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 wr_en,
  input  logic [data_size-1:0] wr_data,
  input  logic                 rd_en,
  output logic [data_size-1:0] rd_data,
  output logic                 is_empty,
  output logic                 is_full,
  output logic                 overflow,
  output logic                 underflow
);
  localparam int pw = $clog2(fifo_depth) + 1;
  logic [pw-1:0] r_wr_ptr, r_rd_ptr;
  logic [data_size-1:0] r_mem [fifo_depth];
  logic r_overflow, r_underflow;
  logic w_push, w_pop;
  always_comb begin
    is_empty  = r_wr_ptr == r_rd_ptr;
    is_full   = (r_wr_ptr[pw-2:0] == r_rd_ptr[pw-2:0]) && (r_wr_ptr[pw-1] != r_rd_ptr[pw-1]);
    w_pop     = rd_en && !is_empty;
    // a pop on a full FIFO frees the slot this push lands in
    w_push    = wr_en && (!is_full || rd_en);
    rd_data   = is_empty ? '0 : r_mem[r_rd_ptr[pw-2:0]];
    overflow  = r_overflow;
    underflow = r_underflow;
  end
  always_ff @(posedge w_clk)
    if (!reset || clear) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ptr    <= r_wr_ptr + pw'(w_push);
      r_rd_ptr    <= r_rd_ptr + pw'(w_pop);
      r_overflow  <= r_overflow | (wr_en && is_full && !rd_en);
      r_underflow <= r_underflow | (rd_en && is_empty);
    end
  always_ff @(posedge w_clk)
    if (reset && !clear && w_push) r_mem[r_wr_ptr[pw-2:0]] <= wr_data;
endmodule

// File: rtl/column_result_fifo_array.sv
// column_result_fifo_array: bank of per-column show-ahead result FIFOs; wr_*/rd_* and status flags are packed one lane per column
module column_result_fifo_array
  import column_result_fifo_array_pkg::*;
#(
  parameter int data_size  = DATA_SIZE,
  parameter int array_size = ARRAY_SIZE,
  parameter int fifo_depth = FIFO_DEPTH
) (
  input  logic                            w_clk,
  input  logic                            reset,
  input  logic                            clear,
  input  logic [array_size-1:0]           wr_en,
  input  logic [array_size*data_size-1:0] wr_data,
  input  logic [array_size-1:0]           rd_en,
  output logic [array_size*data_size-1:0] rd_data,
  output logic [array_size-1:0]           is_empty,
  output logic [array_size-1:0]           is_full,
  output logic [array_size-1:0]           overflow,
  output logic [array_size-1:0]           underflow
);
  for (genvar g = 0; g < array_size; g++) begin : g_col
    column_fifo #(.data_size(data_size), .fifo_depth(fifo_depth)) u_fifo (
      .w_clk    (w_clk),
      .reset    (reset),
      .clear    (clear),
      .wr_en    (wr_en[g]),
      .wr_data  (wr_data[g*data_size +: data_size]),
      .rd_en    (rd_en[g]),
      .rd_data  (rd_data[g*data_size +: data_size]),
      .is_empty (is_empty[g]),
      .is_full  (is_full[g]),
      .overflow (overflow[g]),
      .underflow(underflow[g])
    );
  end
endmodule

// File: tb/tb_column_result_fifo_array.sv
// tb_column_result_fifo_array: randomized and directed checks against a queue model
module tb_column_result_fifo_array;
  localparam int DS = 16, AS = 9, FD = 16;
  logic w_clk = 0, reset = 0, clear = 0;
  logic [AS-1:0] wr_en = '0, rd_en = '0;
  logic [AS*DS-1:0] wr_data = '0, rd_data;
  logic [AS-1:0] is_empty, is_full, overflow, underflow;
  logic [DS-1:0] mq [AS][$];
  logic [AS-1:0] m_ovf = '0, m_unf = '0;
  int checks = 0, failures = 0;
  always #5 w_clk = ~w_clk;
  column_result_fifo_array #(.data_size(DS), .array_size(AS), .fifo_depth(FD)) dut (
    .w_clk(w_clk), .reset(reset), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .is_empty(is_empty), .is_full(is_full),
    .overflow(overflow), .underflow(underflow)
  );
  task automatic chk(input string tag, input logic [AS*DS-1:0] got, input logic [AS*DS-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic check_all();
    logic [AS*DS-1:0] e_data = '0;
    logic [AS-1:0] e_emp = '0, e_full = '0;
    for (int i = 0; i < AS; i++) begin
      e_emp[i] = mq[i].size() == 0;
      e_full[i] = mq[i].size() == FD;
      if (mq[i].size() != 0) e_data[i*DS +: DS] = mq[i][0];
    end
    chk("rd_data", rd_data, e_data);
    chk("is_empty", {135'd0, is_empty}, {135'd0, e_emp});
    chk("is_full", {135'd0, is_full}, {135'd0, e_full});
    chk("overflow", {135'd0, overflow}, {135'd0, m_ovf});
    chk("underflow", {135'd0, underflow}, {135'd0, m_unf});
  endtask
  task automatic step();
    for (int i = 0; i < AS; i++) begin
      if (!reset || clear) begin
        mq[i].delete();
        m_ovf[i] = 0;
        m_unf[i] = 0;
      end else begin
        bit full = mq[i].size() == FD, empty = mq[i].size() == 0;
        bit push = wr_en[i] && (!full || rd_en[i]);
        if (rd_en[i] && empty) m_unf[i] = 1;
        if (wr_en[i] && full && !rd_en[i]) m_ovf[i] = 1;
        if (rd_en[i] && !empty) void'(mq[i].pop_front());
        if (push) mq[i].push_back(wr_data[i*DS +: DS]);
      end
    end
    @(posedge w_clk);
    #1;
    check_all();
  endtask
  task automatic drive(input logic [AS-1:0] w, input logic [AS-1:0] r, input int col, input logic [DS-1:0] v);
    wr_en = w;
    rd_en = r;
    wr_data = '0;
    wr_data[col*DS +: DS] = v;
  endtask
  initial begin
    drive('1, '0, 0, 16'hFFFF);
    step();
    step();
    chk("rst_empty", {135'd0, is_empty}, {135'd0, 9'h1FF});
    chk("rst_full", {135'd0, is_full}, '0);
    chk("rst_data", rd_data, '0);
    reset = 1;
    for (int k = 1; k <= 16; k++) begin
      drive(9'b1 << 3, '0, 3, DS'(k));
      step();
      if (k == 1) chk("c3_first_head", {128'd0, rd_data[3*DS +: DS]}, 144'd1);
    end
    chk("c3_full", {143'd0, is_full[3]}, 144'd1);
    for (int k = 1; k <= 16; k++) begin
      chk("c3_order", {128'd0, rd_data[3*DS +: DS]}, 144'(k));
      drive('0, 9'b1 << 3, 0, '0);
      step();
    end
    chk("c3_empty", {143'd0, is_empty[3]}, 144'd1);
    chk("c3_zero", {128'd0, rd_data[3*DS +: DS]}, 144'd0);
    for (int k = 1; k <= 16; k++) begin
      drive(9'b1, '0, 0, DS'(100 + k));
      step();
    end
    drive(9'b1, '0, 0, 16'hABCD);
    step();
    chk("c0_overflow", {143'd0, overflow[0]}, 144'd1);
    drive(9'b1, 9'b1, 0, 16'h0055);
    step();
    chk("c0_full_pp", {143'd0, is_full[0]}, 144'd1);
    chk("c0_head_adv", {128'd0, rd_data[DS-1:0]}, 144'd102);
    for (int k = 0; k < 16; k++) begin
      chk("c0_drain", {128'd0, rd_data[DS-1:0]}, k == 15 ? 144'h55 : 144'(102 + k));
      drive('0, 9'b1, 0, '0);
      step();
    end
    chk("c0_drained", {143'd0, is_empty[0]}, 144'd1);
    drive(9'b1 << 5, 9'b1 << 5, 5, 16'd7);
    step();
    chk("c5_underflow", {143'd0, underflow[5]}, 144'd1);
    chk("c5_not_empty", {143'd0, is_empty[5]}, 144'd0);
    chk("c5_data", {128'd0, rd_data[5*DS +: DS]}, 144'd7);
    for (int n = 0; n < 80; n++) begin
      wr_data = {$urandom, $urandom, $urandom, $urandom, $urandom};
      for (int i = 0; i < AS; i++) begin
        wr_en[i] = $urandom_range(0, 9) < (n < 40 ? 7 : 4);
        rd_en[i] = $urandom_range(0, 9) < (n < 40 ? 3 : 6);
      end
      step();
    end
    drive('1, '1, 0, 16'h1234);
    wr_data = '1;
    clear = 1;
    step();
    clear = 0;
    drive('0, '0, 0, '0);
    chk("clr_empty", {135'd0, is_empty}, {135'd0, 9'h1FF});
    chk("clr_ovf", {135'd0, overflow}, '0);
    chk("clr_unf", {135'd0, underflow}, '0);
    step();
    chk("clr_data", rd_data, '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
